// File: rtl/apx_float_error_monitor_if.sv
// apx_float_error_monitor_if: pair-input and result-output streams of the float error monitor
interface apx_float_error_monitor_if;
    logic [31:0] input_acc;
    logic [31:0] input_apx;
    logic        input_stb;
    logic        input_ack;
    logic [31:0] output_err;
    logic        output_mismatch;
    logic        output_stb;
    logic        output_ack;
    modport master (
        output input_acc, input_apx, input_stb, output_ack,
        input  input_ack, output_err, output_mismatch, output_stb
    );
    modport slave (
        input  input_acc, input_apx, input_stb, output_ack,
        output input_ack, output_err, output_mismatch, output_stb
    );
endinterface

// File: rtl/apx_float_error_monitor.sv
// apx_float_error_monitor: ULP-distance checker between accurate and approximate float results with saturating statistics
module apx_float_error_monitor #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SUM_W = 40,
    parameter logic [31:0] TOL   = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    apx_float_error_monitor_if.slave bus,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [31:0]          max_err,
    output logic [SUM_W-1:0]     sum_err
);
    typedef enum logic [1:0] {GET, ORD, DIFF, PUT} state_t;
    state_t             r_state;
    logic [31:0]        r_acc, r_apx, r_key_acc, r_key_apx, r_err;
    logic               r_nan_acc, r_nan_apx, r_mm, r_input_ack, r_output_stb;
    logic [CNT_W-1:0]   r_sc, r_mc;
    logic [31:0]        r_max;
    logic [SUM_W-1:0]   r_sum;
    logic [31:0]        w_key_acc, w_key_apx, w_diff, w_err;
    logic               w_nan_acc, w_nan_apx, w_mm;
    logic [SUM_W:0]     w_sum;

    // Sign-magnitude floats become monotonic unsigned keys; both zeros land on 8000_0000
    assign w_key_acc = r_acc[31] ? 32'h8000_0000 - {1'b0, r_acc[30:0]} : 32'h8000_0000 + {1'b0, r_acc[30:0]};
    assign w_key_apx = r_apx[31] ? 32'h8000_0000 - {1'b0, r_apx[30:0]} : 32'h8000_0000 + {1'b0, r_apx[30:0]};
    assign w_nan_acc = (&r_acc[30:23]) && (|r_acc[22:0]);
    assign w_nan_apx = (&r_apx[30:23]) && (|r_apx[22:0]);

    // Two NaNs agree, a lone NaN is maximally wrong, otherwise absolute key distance
    assign w_diff = (r_key_acc >= r_key_apx) ? r_key_acc - r_key_apx : r_key_apx - r_key_acc;
    assign w_err  = (r_nan_acc && r_nan_apx) ? 32'd0 : (r_nan_acc ^ r_nan_apx) ? 32'hFFFF_FFFF : w_diff;
    assign w_mm   = w_err > TOL;
    assign w_sum  = {1'b0, r_sum} + (SUM_W+1)'(w_err);

    assign bus.input_ack       = r_input_ack;
    assign bus.output_stb      = r_output_stb;
    assign bus.output_err      = r_err;
    assign bus.output_mismatch = r_mm;
    assign sample_count        = r_sc;
    assign mismatch_count      = r_mc;
    assign max_err             = r_max;
    assign sum_err             = r_sum;

    // Handshake FSM: capture pair, order-map, diff, present result until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= GET;
            r_input_ack  <= 1'b0;
            r_output_stb <= 1'b0;
            r_acc        <= '0;
            r_apx        <= '0;
            r_key_acc    <= '0;
            r_key_apx    <= '0;
            r_nan_acc    <= 1'b0;
            r_nan_apx    <= 1'b0;
            r_err        <= '0;
            r_mm         <= 1'b0;
        end else begin
            case (r_state)
                GET: begin
                    if (!r_input_ack) begin
                        r_input_ack <= 1'b1;
                    end else if (bus.input_stb) begin
                        r_acc       <= bus.input_acc;
                        r_apx       <= bus.input_apx;
                        r_input_ack <= 1'b0;
                        r_state     <= ORD;
                    end
                end
                ORD: begin
                    r_key_acc <= w_key_acc;
                    r_key_apx <= w_key_apx;
                    r_nan_acc <= w_nan_acc;
                    r_nan_apx <= w_nan_apx;
                    r_state   <= DIFF;
                end
                DIFF: begin
                    r_err        <= w_err;
                    r_mm         <= w_mm;
                    r_output_stb <= 1'b1;
                    r_state      <= PUT;
                end
                PUT: begin
                    if (bus.output_ack) begin
                        r_output_stb <= 1'b0;
                        r_input_ack  <= 1'b1;
                        r_state      <= GET;
                    end
                end
            endcase
        end
    end

    // Saturating statistics; clear wins over the DIFF update on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc  <= '0;
            r_mc  <= '0;
            r_max <= '0;
            r_sum <= '0;
        end else if (clear) begin
            r_sc  <= '0;
            r_mc  <= '0;
            r_max <= '0;
            r_sum <= '0;
        end else if (r_state == DIFF) begin
            r_sc  <= (&r_sc) ? r_sc : r_sc + 1'b1;
            r_mc  <= (w_mm && !(&r_mc)) ? r_mc + 1'b1 : r_mc;
            r_max <= (w_err > r_max) ? w_err : r_max;
            r_sum <= w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];
        end
    end
endmodule

// File: tb/tb_apx_float_error_monitor.sv
// tb_apx_float_error_monitor: directed checks of the float error monitor with TOL=0 and TOL=2/CNT_W=4 instances in lockstep
module tb_apx_float_error_monitor;
    logic clk, rst, clear;
    int checks = 0;
    int errors = 0;
    logic [15:0] a_sc, a_mc;
    logic [3:0]  b_sc, b_mc;
    logic [31:0] a_max, b_max;
    logic [39:0] a_sum, b_sum;

    apx_float_error_monitor_if ia();
    apx_float_error_monitor_if ib();

    apx_float_error_monitor da (
        .clk(clk), .rst(rst), .clear(clear), .bus(ia.slave),
        .sample_count(a_sc), .mismatch_count(a_mc), .max_err(a_max), .sum_err(a_sum)
    );

    apx_float_error_monitor #(.CNT_W(4), .TOL(32'd2)) db (
        .clk(clk), .rst(rst), .clear(clear), .bus(ib.slave),
        .sample_count(b_sc), .mismatch_count(b_mc), .max_err(b_max), .sum_err(b_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input and output handshakes must never be offered together
    always @(negedge clk) begin
        if (rst) begin
            assert (!(ia.input_ack && ia.output_stb)) else begin
                errors++;
                $error("FAIL ack_stb_overlap: input_ack=%0b output_stb=%0b required not both 1", ia.input_ack, ia.output_stb);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a pair to both instances; returns 1 time unit after the DIFF edge T+2
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit clr_diff);
        int n = 0;
        ia.input_acc = a; ia.input_apx = b; ia.input_stb = 1'b1;
        ib.input_acc = a; ib.input_apx = b; ib.input_stb = 1'b1;
        while (!ia.input_ack && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", {63'd0, n < 16}, 64'd1);
        @(posedge clk); #1;
        ia.input_stb = 1'b0;
        ib.input_stb = 1'b0;
        chk("ack_drop", ia.input_ack, 0);
        @(posedge clk); #1;
        chk("stb_early", ia.output_stb, 0);
        if (clr_diff) clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("stb_t3_a", ia.output_stb, 1);
        chk("stb_t3_b", ib.output_stb, 1);
    endtask

    // Consume the presented result with output_ack already high
    task automatic drain();
        @(posedge clk); #1;
        chk("drain_stb", ia.output_stb, 0);
        chk("drain_ack", ia.input_ack, 1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        ia.input_acc = '0; ia.input_apx = '0; ia.input_stb = 1'b0; ia.output_ack = 1'b1;
        ib.input_acc = '0; ib.input_apx = '0; ib.input_stb = 1'b0; ib.output_ack = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ack", ia.input_ack, 0);
        chk("rst_out_stb", ia.output_stb, 0);
        chk("rst_err", ia.output_err, 0);
        chk("rst_mm", ia.output_mismatch, 0);
        chk("rst_stats", {a_sc, a_mc, a_max}, 0);
        chk("rst_sum", a_sum, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rel_ack_low", ia.input_ack, 0);
        @(posedge clk); #1;
        chk("rel_ack_high", ia.input_ack, 1);

        // Latency and 1-ULP distance
        send(32'h3F99999A, 32'h3F99999B, 1'b0);
        chk("ulp_err", ia.output_err, 32'd1);
        chk("ulp_mm", ia.output_mismatch, 1);
        chk("ulp_sc", a_sc, 1);
        chk("ulp_mc", a_mc, 1);
        chk("ulp_max", a_max, 1);
        chk("ulp_sum", a_sum, 1);
        chk("ulp_mm_tol2", ib.output_mismatch, 0);
        chk("ulp_mc_tol2", b_mc, 0);
        drain();

        // Signed zeros, then opposite signs
        pulse_clear();
        send(32'h0000_0000, 32'h8000_0000, 1'b0);
        chk("zero_err", ia.output_err, 0);
        chk("zero_mm", ia.output_mismatch, 0);
        drain();
        send(32'h3F80_0000, 32'hBF80_0000, 1'b0);
        chk("sign_err", ia.output_err, 32'h7F00_0000);
        chk("sign_mm", ia.output_mismatch, 1);
        chk("sign_max", a_max, 32'h7F00_0000);
        chk("sign_sum", a_sum, 40'h7F00_0000);
        chk("sign_sc", a_sc, 2);
        chk("sign_mc", a_mc, 1);
        drain();

        // NaN handling
        pulse_clear();
        send(32'h7FC0_0000, 32'h3F80_0000, 1'b0);
        chk("nan1_err", ia.output_err, 32'hFFFF_FFFF);
        chk("nan1_mm", ia.output_mismatch, 1);
        chk("nan1_mm_tol2", ib.output_mismatch, 1);
        drain();
        send(32'h7FC0_0000, 32'h7FC0_0001, 1'b0);
        chk("nan2_err", ia.output_err, 0);
        chk("nan2_mm", ia.output_mismatch, 0);
        chk("nan_sum", a_sum, 40'hFFFF_FFFF);
        chk("nan_max", a_max, 32'hFFFF_FFFF);
        chk("nan_mc", a_mc, 1);
        chk("nan_sum_b", b_sum, 40'hFFFF_FFFF);
        drain();

        // Tolerance of 2 ULP on instance b
        pulse_clear();
        send(32'h3F99999A, 32'h3F99999B, 1'b0);
        chk("tol_e1_err", ib.output_err, 1);
        chk("tol_e1_mm", ib.output_mismatch, 0);
        drain();
        send(32'h3F99999A, 32'h3F99999D, 1'b0);
        chk("tol_e3_err", ib.output_err, 3);
        chk("tol_e3_mm", ib.output_mismatch, 1);
        chk("tol_mc_b", b_mc, 1);
        chk("tol_mc_a", a_mc, 2);
        drain();

        // Back-pressure stalls PUT
        ia.output_ack = 1'b0;
        ib.output_ack = 1'b0;
        send(32'h3F80_0000, 32'h3F80_0002, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_stb", ia.output_stb, 1);
            chk("bp_ack", ia.input_ack, 0);
        end
        chk("bp_err_hold", ia.output_err, 2);
        chk("bp_sc", a_sc, 3);
        ia.output_ack = 1'b1;
        ib.output_ack = 1'b1;
        drain();

        // clear coincident with DIFF: statistics lost, pair still emitted
        send(32'h3F99999A, 32'h3F99999D, 1'b1);
        chk("clrd_err", ia.output_err, 3);
        chk("clrd_mm", ia.output_mismatch, 1);
        chk("clrd_sc", a_sc, 0);
        chk("clrd_mc", a_mc, 0);
        chk("clrd_max", a_max, 0);
        chk("clrd_sum", a_sum, 0);
        drain();

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            send(32'h3F99999A, 32'h3F99999D, 1'b0);
            drain();
        end
        chk("sat_sc_b", b_sc, 4'hF);
        chk("sat_mc_b", b_mc, 4'hF);
        chk("sat_sc_a", a_sc, 20);
        chk("sat_mc_a", a_mc, 20);
        chk("sat_sum_b", b_sum, 60);
        chk("sat_max_b", b_max, 3);

        // Reset mid-operation discards the in-flight pair
        ia.output_ack = 1'b0;
        ib.output_ack = 1'b0;
        send(32'h3F80_0000, 32'hBF80_0000, 1'b0);
        rst = 1'b0;
        #1;
        chk("mrst_stb", ia.output_stb, 0);
        chk("mrst_err", ia.output_err, 0);
        chk("mrst_sc", a_sc, 0);
        chk("mrst_sum_b", b_sum, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        ia.output_ack = 1'b1;
        ib.output_ack = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ack", ia.input_ack, 1);
        chk("mrst_stb2", ia.output_stb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
